// File: rtl/decode_stage_if.sv
// Fetch/writeback-to-decode and decode-to-execute signal bundle.
// No storage: pure wiring, zero latency.
// stall_o is the only backpressure signal: it tells fetch to hold its word.
interface decode_stage_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32
);
  // fetch side
  logic              if_valid;
  logic [15:0]       if_instr;
  logic [PC_W-1:0]   if_pc;
  logic              stall_o;
  // later-stage control and writeback
  logic              flush;
  logic              wb_en;
  logic [2:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  // ID/EX bundle
  logic              id_valid;
  logic [PC_W-1:0]   id_pc;
  logic [5:0]        id_opcode;
  logic [2:0]        id_src;
  logic [2:0]        id_dst;
  logic [3:0]        id_shamt;
  logic [DATA_W-1:0] id_src_val;
  logic [DATA_W-1:0] id_dst_val;
  logic [3:0]        id_alu_op;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_illegal;

  modport master (
    output if_valid, if_instr, if_pc, flush, wb_en, wb_addr, wb_data,
    input  stall_o, id_valid, id_pc, id_opcode, id_src, id_dst, id_shamt,
           id_src_val, id_dst_val, id_alu_op, id_reg_write, id_mem_read,
           id_mem_write, id_illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush, wb_en, wb_addr, wb_data,
    output stall_o, id_valid, id_pc, id_opcode, id_src, id_dst, id_shamt,
           id_src_val, id_dst_val, id_alu_op, id_reg_write, id_mem_read,
           id_mem_write, id_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, 8x16 register file, load-use hazard detect, ID/EX register.
// Latency: word accepted into IF/ID at edge N is visible on id_* after edge N+1.
// Backpressure: stall_o holds fetch for one cycle on a load-use hazard; flush overrides stall.
module decode_stage #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32,
  parameter int NREGS  = 8
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [5:0]        opcode;
    logic [2:0]        src;
    logic [2:0]        dst;
    logic [3:0]        shamt;
    logic [DATA_W-1:0] src_val;
    logic [DATA_W-1:0] dst_val;
    logic [3:0]        alu_op;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              illegal;
  } idex_t;

  logic              ifid_valid;
  logic [15:0]       ifid_instr;
  logic [PC_W-1:0]   ifid_pc;
  logic [DATA_W-1:0] rf [NREGS];
  idex_t             id_q, id_d;

  logic [5:0]        opcode;
  logic [2:0]        src, dst;
  logic [3:0]        shamt;
  logic              rd_src, rd_dst, reg_write, mem_read, mem_write, illegal;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] src_raw, dst_raw;
  logic              stall;

  assign opcode = ifid_instr[15:10];
  assign src    = ifid_instr[9:7];
  assign dst    = ifid_instr[6:4];
  assign shamt  = ifid_instr[3:0];

  // Opcode decode: which operands are read and which control lines are raised
  always_comb begin
    rd_src    = 1'b0;
    rd_dst    = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    illegal   = 1'b0;
    alu_op    = 4'h0;
    case (opcode)
      6'h00: begin end
      6'h01: begin rd_src = 1'b1; reg_write = 1'b1; end
      6'h02, 6'h03, 6'h04, 6'h05: begin
        rd_src = 1'b1; rd_dst = 1'b1; reg_write = 1'b1;
      end
      6'h06, 6'h07: begin rd_dst = 1'b1; reg_write = 1'b1; end
      6'h08: begin rd_src = 1'b1; mem_read = 1'b1; reg_write = 1'b1; end
      6'h09: begin rd_src = 1'b1; rd_dst = 1'b1; mem_write = 1'b1; end
      default: illegal = 1'b1;
    endcase
    if (opcode >= 6'h01 && opcode <= 6'h07) alu_op = opcode[3:0];
  end

  // Register read with same-cycle write-through from writeback
  assign src_raw = (bus.wb_en && bus.wb_addr == src) ? bus.wb_data : rf[src];
  assign dst_raw = (bus.wb_en && bus.wb_addr == dst) ? bus.wb_data : rf[dst];

  // Load-use: the LDD now in ID/EX produces a register the IF/ID word reads.
  // mem_read is only ever set together with valid, so it identifies a live LDD.
  assign stall = !bus.flush && ifid_valid && id_q.mem_read &&
                 ((rd_src && src == id_q.dst) || (rd_dst && dst == id_q.dst));

  // IF/ID register: flush empties it, a stall freezes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
    end else if (bus.flush) begin
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_valid <= bus.if_valid;
      ifid_instr <= bus.if_instr;
      ifid_pc    <= bus.if_pc;
    end
  end

  // Register file: one write port from writeback, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (bus.wb_en) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Next ID/EX bundle: all-zero bubble unless a live, unstalled, unflushed word is decoded
  always_comb begin
    id_d = '0;
    if (ifid_valid && !stall && !bus.flush) begin
      id_d.valid     = 1'b1;
      id_d.pc        = ifid_pc;
      id_d.opcode    = opcode;
      id_d.src       = src;
      id_d.dst       = dst;
      id_d.shamt     = shamt;
      id_d.src_val   = rd_src ? src_raw : '0;
      id_d.dst_val   = rd_dst ? dst_raw : '0;
      id_d.alu_op    = alu_op;
      id_d.reg_write = reg_write;
      id_d.mem_read  = mem_read;
      id_d.mem_write = mem_write;
      id_d.illegal   = illegal;
    end
  end

  // ID/EX register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) id_q <= '0;
    else     id_q <= id_d;
  end

  assign bus.stall_o      = stall;
  assign bus.id_valid     = id_q.valid;
  assign bus.id_pc        = id_q.pc;
  assign bus.id_opcode    = id_q.opcode;
  assign bus.id_src       = id_q.src;
  assign bus.id_dst       = id_q.dst;
  assign bus.id_shamt     = id_q.shamt;
  assign bus.id_src_val   = id_q.src_val;
  assign bus.id_dst_val   = id_q.dst_val;
  assign bus.id_alu_op    = id_q.alu_op;
  assign bus.id_reg_write = id_q.reg_write;
  assign bus.id_mem_read  = id_q.mem_read;
  assign bus.id_mem_write = id_q.mem_write;
  assign bus.id_illegal   = id_q.illegal;

endmodule
